seg_scan_controller: RTL

Sequences the board's 8-digit multiplexed seven-segment display. Owns digit scanning, inter-digit blanking (anti-ghosting), per-digit brightness PWM and a tear-free double-buffered frame update. Sits between the character/pattern sources (upstream, via valid/ready) and the SEG/AN pins. Replaces the free-running divider, counter and anode-decode chain.

---
 rtl/seg_scan_pkg.sv | 24 ++
 rtl/seg_scan_controller_scan_timer.sv | 74 +++++++
 rtl/seg_scan_controller.sv | 104 ++++++++++
 3 files changed

// File: rtl/seg_scan_pkg.sv
// Shared types and constants for the multiplexed seven-segment scan controller.
package seg_scan_pkg;

  localparam int unsigned NUM_DIGITS = 8;
  localparam int unsigned SEG_W      = 7;
  localparam int unsigned IDX_W      = 3;

  typedef logic [SEG_W-1:0] seg_pattern_t;
  typedef seg_pattern_t [NUM_DIGITS-1:0] frame_t;

  typedef enum logic {
    BLANK = 1'b0,
    ON    = 1'b1
  } scan_state_t;

  localparam seg_pattern_t            SEG_OFF_N = 7'h7F;
  localparam logic [NUM_DIGITS-1:0]   AN_OFF_N  = 8'hFF;

  // Active-low one-hot anode select for a digit index.
  function automatic logic [NUM_DIGITS-1:0] an_select_n(input logic [IDX_W-1:0] idx);
    return ~(NUM_DIGITS'(1) << idx);
  endfunction

endpackage

// File: rtl/seg_scan_controller_scan_timer.sv
// Slot counter and BLANK/ON sequencing; scan_idx and frame_done are delayed one
// cycle so they line up with the registered pins derived from the raw counter.
module scan_timer
  import seg_scan_pkg::*;
#(
  parameter int unsigned DIGIT_TICKS = 12500,
  parameter int unsigned BLANK_TICKS = 500,
  parameter int unsigned CNT_W       = $clog2(BLANK_TICKS + DIGIT_TICKS)
) (
  input  logic             clk,
  input  logic             reset_n,
  output scan_state_t      o_state,
  output logic [CNT_W-1:0] o_cnt,
  output logic [IDX_W-1:0] o_idx,
  output logic [IDX_W-1:0] o_scan_idx,
  output logic             o_frame_done
);

  localparam int unsigned SLOT_TICKS = BLANK_TICKS + DIGIT_TICKS;

  scan_state_t      r_state;
  scan_state_t      w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [IDX_W-1:0] r_idx;
  logic [IDX_W-1:0] w_idx_nxt;
  logic [IDX_W-1:0] r_scan_idx;
  logic             r_frame_done;
  logic             w_slot_last;

  assign w_slot_last = (r_cnt == CNT_W'(SLOT_TICKS - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= BLANK;
      r_cnt        <= '0;
      r_idx        <= '0;
      r_scan_idx   <= '0;
      r_frame_done <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_idx        <= w_idx_nxt;
      r_scan_idx   <= r_idx;
      r_frame_done <= w_slot_last && (r_idx == IDX_W'(NUM_DIGITS - 1));
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt + CNT_W'(1);
    w_idx_nxt   = r_idx;
    unique case (r_state)
      BLANK: begin
        if (r_cnt == CNT_W'(BLANK_TICKS - 1)) w_state_nxt = ON;
      end
      ON: begin
        if (w_slot_last) begin
          w_state_nxt = BLANK;
          w_cnt_nxt   = '0;
          w_idx_nxt   = r_idx + IDX_W'(1);
        end
      end
      default: w_state_nxt = BLANK;
    endcase
  end

  assign o_state      = r_state;
  assign o_cnt        = r_cnt;
  assign o_idx        = r_idx;
  assign o_scan_idx   = r_scan_idx;
  assign o_frame_done = r_frame_done;

endmodule

// File: rtl/seg_scan_controller.sv
// 8-digit seven-segment scan controller: double-buffered frame, per-digit
// enable, brightness PWM and registered SEG/AN pins.
module seg_scan_controller
  import seg_scan_pkg::*;
#(
  parameter int unsigned DIGIT_TICKS = 12500,
  parameter int unsigned BLANK_TICKS = 500,
  parameter int unsigned BRIGHT_W    = 3
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic [NUM_DIGITS*SEG_W-1:0] frame_data,
  input  logic                        frame_valid,
  output logic                        frame_ready,
  input  logic [NUM_DIGITS-1:0]       digit_en,
  input  logic [BRIGHT_W-1:0]         brightness,
  output logic [SEG_W-1:0]            seg_n,
  output logic [NUM_DIGITS-1:0]       an_n,
  output logic [IDX_W-1:0]            scan_idx,
  output logic                        frame_done
);

  localparam int unsigned CNT_W = $clog2(BLANK_TICKS + DIGIT_TICKS);
  localparam int unsigned THR_W = $clog2(DIGIT_TICKS) + 1;
  localparam int unsigned CMP_W = CNT_W + THR_W;
  localparam int unsigned STEP  = DIGIT_TICKS / 8;

  scan_state_t      w_state;
  logic [CNT_W-1:0] w_cnt;
  logic [IDX_W-1:0] w_idx;
  logic             w_frame_done;
  logic [CNT_W-1:0] w_on_cnt;
  logic [THR_W-1:0] w_thr;
  logic             w_lit;

  frame_t                r_active;
  frame_t                r_pending;
  logic                  r_frame_ready;
  logic                  r_slot_en;
  logic [THR_W-1:0]      r_thr;
  logic [SEG_W-1:0]      r_seg_n;
  logic [NUM_DIGITS-1:0] r_an_n;

  scan_timer #(
    .DIGIT_TICKS (DIGIT_TICKS),
    .BLANK_TICKS (BLANK_TICKS),
    .CNT_W       (CNT_W)
  ) u_scan_timer (
    .clk          (clk),
    .reset_n      (reset_n),
    .o_state      (w_state),
    .o_cnt        (w_cnt),
    .o_idx        (w_idx),
    .o_scan_idx   (scan_idx),
    .o_frame_done (w_frame_done)
  );

  assign w_on_cnt = w_cnt - CNT_W'(BLANK_TICKS);
  assign w_thr    = (THR_W'(brightness) + THR_W'(1)) * THR_W'(STEP);

  // The first ON cycle is always lit (thr >= 1), so brightness can be captured then.
  always_comb begin
    w_lit = 1'b0;
    if (w_state == ON && r_slot_en) begin
      if (w_on_cnt == '0) w_lit = 1'b1;
      else                w_lit = (CMP_W'(w_on_cnt) < CMP_W'(r_thr));
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_slot_en <= 1'b0;
      r_thr     <= '0;
      r_seg_n   <= SEG_OFF_N;
      r_an_n    <= AN_OFF_N;
    end else begin
      if (w_cnt == '0)                      r_slot_en <= digit_en[w_idx];
      if (w_state == ON && w_on_cnt == '0)  r_thr     <= w_thr;
      r_an_n  <= w_lit ? an_select_n(w_idx) : AN_OFF_N;
      r_seg_n <= w_lit ? ~r_active[w_idx]   : SEG_OFF_N;
    end
  end

  // Pending buffer accepts when empty; promotion only at frame_done, so no tearing.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_active      <= '0;
      r_pending     <= '0;
      r_frame_ready <= 1'b1;
    end else if (frame_valid && r_frame_ready) begin
      r_pending     <= frame_data;
      r_frame_ready <= 1'b0;
    end else if (w_frame_done && !r_frame_ready) begin
      r_active      <= r_pending;
      r_frame_ready <= 1'b1;
    end
  end

  assign frame_ready = r_frame_ready;
  assign seg_n       = r_seg_n;
  assign an_n        = r_an_n;
  assign frame_done  = w_frame_done;

endmodule
